sync_ram_arbiter: RTL

Two-requester arbiter and initialiser for the single-port 16x8 synchronous RAM. It zero-fills the RAM after reset. It then shares the RAM's single address/write port between two requesters using round-robin arbitration with a valid/ready handshake. It returns a one-cycle response pulse per accepted command, carrying the RAM's registered read data. It sits directly in front of the RAM, and the RAM's own rst input is tied low.

---
 rtl/sync_ram_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/sync_ram_arbiter.sv
// Round-robin two-requester front end for a single-port synchronous RAM.
// Zero-fills the RAM after reset, then returns one response pulse per accepted command.
module sync_ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          init_done
);
    localparam int DEPTH  = 1 << AW;
    localparam int STAGES = 2;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt;
    logic            last_id;   // requester served most recently; the other wins a tie
    logic            gnt0, gnt1, accept, init_last;
    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] id_pipe;

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        init_last = (state == INIT) && (cnt == AW'(DEPTH - 1));
        if (state == RUN) begin
            gnt0 = req0_valid & (~req1_valid | last_id);
            gnt1 = req1_valid & (~req0_valid | ~last_id);
        end
        if (init_last)
            state_nxt = RUN;
    end

    assign accept     = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Response pipe: stage 1 = RAM sees the command, stage 2 = ram_dout valid.
    assign rsp0_valid = vld_pipe[STAGES] & ~id_pipe[STAGES];
    assign rsp1_valid = vld_pipe[STAGES] &  id_pipe[STAGES];
    assign rsp0_rdata = ram_dout;
    assign rsp1_rdata = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            last_id   <= 1'b1;
            init_done <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            vld_pipe  <= '0;
            id_pipe   <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            id_pipe  <= {id_pipe[STAGES-1:1], gnt1};
            if (state == INIT) begin
                ram_we   <= 1'b1;
                ram_addr <= cnt;
                ram_din  <= '0;
                cnt      <= cnt + 1'b1;
                if (init_last)
                    init_done <= 1'b1;
            end else if (accept) begin
                ram_we   <= gnt1 ? req1_we    : req0_we;
                ram_addr <= gnt1 ? req1_addr  : req0_addr;
                ram_din  <= gnt1 ? req1_wdata : req0_wdata;
                last_id  <= gnt1;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end
endmodule
